srv_line_fill_mem: RTL and testbench
====================================

// Module: srv_line_fill_mem
// PURPOSE
//  Responder side of the icache external line-fill interface.
//  - Accepts a line request on ext_req_i/ext_addr_i.
//  - Reads four 32-bit words sequentially from the asynchronous instruction ROM.
//  - Assembles them into one 128-bit line.
//  - Returns the line with a one-cycle ext_rsp_o pulse.
//  - Sits between the instruction cache's refill port and the ROM, in the same clock domain as the CPU.
// PARAMETERS
//  WAIT_CYCLES  0   extra stall cycles per ROM beat before rom_data_i is captured (0..15)
//  ADDR_W       32  width of ext_addr_i and rom_addr_o
// PORTS
//  clk         in   1    core clock; all state updates on posedge
//  rst         in   1    synchronous, active-high reset
//  ext_addr_i  in   32   byte address of requested line; bits [3:0] ignored except by the optional feature
//  ext_req_i   in   1    line request; level, held by requester until ext_rsp_o
//  ext_rsp_o   out  1    one-cycle pulse: ext_data_o holds the completed line
//  ext_data_o  out  128  line data; word k (byte offset 4k) in bits [32k+31:32k]
//  rom_addr_o  out  32   ROM word address (byte address >> 2)
//  rom_data_i  in   32   ROM read data, combinational from rom_addr_o
// BEHAVIOUR
//  Interface:
//  - One clock (clk). Reset (rst) is synchronous and active-high.
//  Reset (rst=1 at an edge):
//  - state=IDLE, ext_rsp_o=0, ext_data_o=0, rom_addr_o=0, beat=0, wait counter=0.
//  - Applies from any state; an in-flight fill is discarded with no rsp.
//  States:
//  - IDLE
//    - rom_addr_o=0.
//    - ext_req_i=1 at an edge: latch base={ext_addr_i[31:4],4'b0}, latch start word s, go FETCH.
//    - s=0 unless SRV_LINE_FILL_CRIT_FIRST_EN is defined.
//  - FETCH
//    - beat b in 0..3; word index w=(s+b) mod 4; rom_addr_o={base[31:4],w[1:0]}.
//    - Wait counter counts 0..WAIT_CYCLES.
//    - On the edge where counter==WAIT_CYCLES: ext_data_o[32w+:32] <= rom_data_i; counter<=0; b<=b+1.
//    - Beat b==3 captured: go RESP.
//    - ext_data_o slices not yet captured keep their previous values.
//  - RESP
//    - ext_rsp_o=1 for exactly this cycle; rom_addr_o holds the last word address; next state IDLE.
//  Requests:
//  - ext_req_i is sampled only in IDLE; changes during FETCH/RESP are ignored.
//  - The requester must deassert ext_req_i by the edge after ext_rsp_o=1.
//  - A request still high in IDLE starts a new fill, no gap needed (back-to-back fills allowed).
//  Data holding:
//  - ext_data_o is held unchanged from RESP until the first capture of the next fill.
//  - ext_addr_i is not required to be stable after the accepting edge.
//  Latency:
//  - Edge accepting the request to ext_rsp_o high: 4*(WAIT_CYCLES+1)+1 cycles.
//  - WAIT_CYCLES=0 gives 5 cycles.
//  - Throughput: one line per 4*(WAIT_CYCLES+1)+2 cycles.
//  Arithmetic:
//  - Word index wraps mod 4 inside the aligned line and never crosses into the next line.
//  - No carry into base[31:4].
//  - rom_addr_o upper bits beyond ADDR_W-2 are zero.
// CONFIGURATION
//  SRV_LINE_FILL_CRIT_FIRST_EN defined (critical word first):
//  - s=ext_addr_i[3:2]; beats fetch words s, s+1, s+2, s+3 (mod 4).
//  - Final line contents and latency are identical to the undefined case; only ROM access order changes.
//  SRV_LINE_FILL_CRIT_FIRST_EN undefined:
//  - s=0; order 0,1,2,3; ext_addr_i[3:0] fully ignored.
// TESTING
//  - Reset: hold rst=1 with ext_req_i=1 for 3 cycles -> ext_rsp_o=0, ext_data_o=0, rom_addr_o=0; no fill starts until rst=0.
//  - Basic fill, WAIT_CYCLES=0, ROM word n = 32'hA000_0000+n, req addr 32'h40 -> rom_addr_o 16,17,18,19 on consecutive cycles; rsp 5 cycles after accept; ext_data_o=128'hA000_0013_A000_0012_A000_0011_A000_0010.
//  - Wait states, WAIT_CYCLES=2, addr 32'h0 -> each rom_addr_o held 3 cycles; rsp at cycle 13; ext_rsp_o high exactly 1 cycle.
//  - Critical word first (macro defined), addr 32'h4C -> rom_addr_o order 19,16,17,18; same 128-bit line as the undefined case; same latency.
//  - Back-to-back: req held through rsp of 32'h0, then addr 32'h10 -> second fill starts the cycle after RESP; ext_data_o unchanged until its first capture.
//  - Mid-fill reset: rst=1 during beat 2 -> next cycle IDLE, outputs zero, no rsp; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/srv_line_fill_mem.sv
// srv_line_fill_mem: icache line-fill responder, four sequential ROM beats per line.
// Define SRV_LINE_FILL_CRIT_FIRST_EN to fetch the requested word first.
module srv_line_fill_mem #(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic              ext_req_i,
    output logic              ext_rsp_o,
    output logic [127:0]      ext_data_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);

    logic [1:0]        state;
    logic [ADDR_W-5:0] base;
    logic [1:0]        start;
    logic [1:0]        beat;
    logic [1:0]        word;
    logic [3:0]        wait_cnt;
    logic [1:0]        req_start;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^ext_addr_i[3:0];

`ifdef SRV_LINE_FILL_CRIT_FIRST_EN
    assign req_start = ext_addr_i[3:2];
`else
    assign req_start = 2'd0;
`endif

    // Word index wraps inside the aligned line; no carry into base.
    assign word      = start + beat;
    assign ext_rsp_o = (state == RESP);

    always_comb begin
        rom_addr_o = '0;
        if (state != IDLE) begin
            rom_addr_o = {2'b00, base, word};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            start      <= '0;
            beat       <= '0;
            wait_cnt   <= '0;
            ext_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ext_req_i) begin
                        base     <= ext_addr_i[ADDR_W-1:4];
                        start    <= req_start;
                        beat     <= '0;
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (wait_cnt == WAIT_MAX) begin
                        ext_data_o[{word, 5'b0} +: 32] <= rom_data_i;
                        wait_cnt <= '0;
                        // Beat stays at 3 so RESP keeps the last word address.
                        if (beat == 2'd3) begin
                            state <= RESP;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    beat  <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srv_line_fill_mem.sv
// tb_srv_line_fill_mem: random and directed line fills against a reference model.
// Two instances cover WAIT_CYCLES=0 and WAIT_CYCLES=2; sel picks the active one.
module tb_srv_line_fill_mem;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         sel;
    logic [31:0]  ext_addr;
    logic [31:0]  salt;
    logic         req0, req2, rsp0, rsp2;
    logic [127:0] data0, data2;
    logic [31:0]  ra0, ra2, rd0, rd2;
    logic         rsp_v;
    logic [127:0] data_v;
    logic [31:0]  rom_addr_v;
    logic [127:0] prev [2];
    int           n_tests = 0;
    int           n_fail  = 0;
    localparam logic [127:0] SPEC_LINE = 128'hA000_0013_A000_0012_A000_0011_A000_0010;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a, input logic [31:0] sl);
        if (sl == 32'd0) return 32'hA000_0000 + a;
        return (a * 32'h9E37_79B9) ^ sl;
    endfunction

    assign req0 = req & ~sel;
    assign req2 = req & sel;
    assign rd0  = rom_fn(ra0, salt);
    assign rd2  = rom_fn(ra2, salt);

    assign rsp_v      = sel ? rsp2  : rsp0;
    assign data_v     = sel ? data2 : data0;
    assign rom_addr_v = sel ? ra2   : ra0;

    srv_line_fill_mem #(.WAIT_CYCLES(0), .ADDR_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .ext_addr_i(ext_addr), .ext_req_i(req0),
        .ext_rsp_o(rsp0), .ext_data_o(data0), .rom_addr_o(ra0), .rom_data_i(rd0)
    );

    srv_line_fill_mem #(.WAIT_CYCLES(2), .ADDR_W(32)) u_dut2 (
        .clk(clk), .rst(rst), .ext_addr_i(ext_addr), .ext_req_i(req2),
        .ext_rsp_o(rsp2), .ext_data_o(data2), .rom_addr_o(ra2), .rom_data_i(rd2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_chk();
        check("idle_rsp", 128'(rsp_v), 128'd0);
        check("idle_addr", 128'(rom_addr_v), 128'd0);
        check("idle_hold", data_v, prev[sel]);
    endtask

    // Called at a negedge with req high and the selected DUT idle.
    task automatic run_fill(input logic [31:0] addr);
        int unsigned  w, lat, s, b, wi;
        logic [31:0]  bw;
        logic [127:0] line, cur;
        w   = sel ? 2 : 0;
        lat = 4 * (w + 1) + 1;
        bw  = (addr & ~32'hF) >> 2;
`ifdef SRV_LINE_FILL_CRIT_FIRST_EN
        s = 32'(addr[3:2]);
`else
        s = 0;
`endif
        for (int i = 0; i < 4; i++) line[32*i +: 32] = rom_fn(bw + 32'(i), salt);
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            ext_addr = $urandom;
            if (k < lat) begin
                b   = (k - 1) / (w + 1);
                cur = prev[sel];
                for (int bb = 0; bb < 4; bb++) begin
                    if (bb < b) begin
                        wi = (s + bb) % 4;
                        cur[32*wi +: 32] = line[32*wi +: 32];
                    end
                end
                check("fetch_rsp", 128'(rsp_v), 128'd0);
                check("fetch_addr", 128'(rom_addr_v), 128'(bw + (s + b) % 4));
                check("fetch_data", data_v, cur);
            end else begin
                check("resp_pulse", 128'(rsp_v), 128'd1);
                check("resp_line", data_v, line);
                check("resp_addr", 128'(rom_addr_v), 128'(bw + (s + 3) % 4));
            end
        end
        prev[sel] = line;
    endtask

    task automatic fill_once(input logic s_, input logic [31:0] addr, input bit b2b, input bit hold);
        if (b2b) begin
            ext_addr = addr;
            @(negedge clk);
            idle_chk();
        end else begin
            sel      = s_;
            ext_addr = addr;
            req      = 1'b1;
        end
        run_fill(addr);
        if (!hold) begin
            req = 1'b0;
            @(negedge clk);
            idle_chk();
        end
    endtask

    initial begin
        bit   hold;
        bit   b2b;
        logic s_;
        rst      = 1'b1;
        req      = 1'b1;
        sel      = 1'b0;
        ext_addr = 32'h40;
        salt     = 32'd0;
        prev[0]  = '0;
        prev[1]  = '0;
        repeat (3) begin
            @(negedge clk);
            check("rst_rsp", 128'({rsp0, rsp2}), 128'd0);
            check("rst_data", data0 | data2, 128'd0);
            check("rst_addr", 128'(ra0 | ra2), 128'd0);
        end
        rst = 1'b0;
        req = 1'b0;
        @(negedge clk);
        idle_chk();

        fill_once(1'b0, 32'h40, 1'b0, 1'b0);
        check("spec_line_40", data_v, SPEC_LINE);
        fill_once(1'b0, 32'h4C, 1'b0, 1'b0);
        check("spec_line_4c", data_v, SPEC_LINE);
        fill_once(1'b1, 32'h0, 1'b0, 1'b1);
        fill_once(1'b1, 32'h10, 1'b1, 1'b0);

        sel      = 1'b1;
        ext_addr = 32'h80;
        req      = 1'b1;
        @(posedge clk);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp", 128'(rsp_v), 128'd0);
        check("mid_rst_data", data_v, 128'd0);
        check("mid_rst_addr", 128'(rom_addr_v), 128'd0);
        prev[0] = '0;
        prev[1] = '0;
        rst = 1'b0;
        req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", 128'(rsp_v), 128'd0);
        end
        fill_once(1'b1, 32'h80, 1'b0, 1'b0);

        hold = 1'b0;
        s_   = 1'b0;
        for (int it = 0; it < 24; it++) begin
            b2b = hold;
            if (!b2b) s_ = 1'($urandom_range(0, 1));
            salt = $urandom;
            hold = (it < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            fill_once(s_, $urandom, b2b, hold);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
